bcd_adder_serial: RTL and testbench

- Parametrised multi-digit packed-BCD adder; digit-serial, one BCD digit per clock, LSD first.
- Successor to the single-digit combinational BCD adder: generalised to DIGITS digits, with start/busy/done handshake, invalid-digit flagging and registered results.
- Sits in the arithmetic datapath where wide decimal operands are added without replicating DIGITS combinational correction stages.

---
 rtl/bcd_adder_serial.sv | 226 ++++++++++++++++++++++
 tb/tb_bcd_adder_serial.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_adder_serial.sv
// ---------------------------------------------------------------------------
// bcd_adder_serial
//
// Purpose:
//   Multi-digit packed-BCD adder that works digit-serially, one BCD digit
//   per clock, least significant digit first. A request is accepted with
//   start_i, the operands are latched, DIGITS clocks of digit processing
//   follow, and the registered result is presented with a one-cycle done_o
//   pulse. Throughput is one operation every DIGITS+1 clocks when requests
//   are issued back-to-back in the done cycle.
//
// Optional build macro:
//   BCD_SUB_EN - adds the sub_i port. With sub_i=1 the B operand is nines-
//                complemented digit by digit and the initial carry is forced
//                to 1, so the unit computes A - B (cout_o=1 means no borrow).
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start_i    in   operation request, only looked at while not busy
//   a_i        in   packed BCD operand A, digit i = a_i[4i+3:4i]
//   b_i        in   packed BCD operand B
//   cin_i      in   decimal carry-in
//   sub_i      in   (BCD_SUB_EN only) subtract request, sampled with start_i
//   busy_o     out  high while digits are being processed
//   done_o     out  one-cycle pulse, result outputs just updated
//   sum_o      out  packed BCD result of the last completed operation
//   cout_o     out  decimal carry-out of the most significant digit
//   invalid_o  out  some input digit of the last operation was above 9
// ---------------------------------------------------------------------------
module bcd_adder_serial #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [4*DIGITS-1:0]   a_i,
  input  logic [4*DIGITS-1:0]   b_i,
  input  logic                  cin_i,
`ifdef BCD_SUB_EN
  input  logic                  sub_i,
`endif
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   sum_o,
  output logic                  cout_o,
  output logic                  invalid_o
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    opA_q, opA_d;
  logic [W-1:0]    opB_q, opB_d;
  logic            carry_q, carry_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    acc_q, acc_d;
  logic            invAcc_q, invAcc_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            invalid_q, invalid_d;
`ifdef BCD_SUB_EN
  logic            subMode_q, subMode_d;
`endif

  logic [3:0]      digitA;
  logic [3:0]      digitBRaw;
  logic [3:0]      digitB;
  logic [4:0]      digitTotal;
  logic [3:0]      digitSum;
  logic            digitCarry;
  logic            digitInvalid;
  logic [W-1:0]    accNext;
  logic            launch;
  logic            launchCarry;

  // The latched operands are shifted right one digit per RUN cycle, so the
  // digit currently being processed always sits in the low nibble. Invalid
  // detection looks at the original B digit, before any complementing.
  always_comb begin
    digitA       = opA_q[3:0];
    digitBRaw    = opB_q[3:0];
`ifdef BCD_SUB_EN
    digitB       = subMode_q ? (4'd9 - digitBRaw) : digitBRaw;
`else
    digitB       = digitBRaw;
`endif
    digitInvalid = (digitA > 4'd9) || (digitBRaw > 4'd9);
    digitTotal   = {1'b0, digitA} + {1'b0, digitB} + {4'b0000, carry_q};
    // Decimal correction: adding 6 skips the six unused nibble codes.
    // Out-of-range digits go through the same rule without saturation.
    if (digitTotal > 5'd9) begin
      digitSum   = digitTotal[3:0] + 4'd6;
      digitCarry = 1'b1;
    end else begin
      digitSum   = digitTotal[3:0];
      digitCarry = 1'b0;
    end
  end

  // Result digits enter the accumulator from the top; after DIGITS shifts
  // the first digit produced has reached the least significant position.
  generate
    if (DIGITS == 1) begin : gAccSingle
      assign accNext = digitSum;
    end else begin : gAccMulti
      assign accNext = {digitSum, acc_q[W-1:4]};
    end
  endgenerate

  // A request is accepted whenever no digits are in flight, which includes
  // the DONE cycle so back-to-back operations lose no cycle.
  always_comb begin
    launch = start_i && (state_q != RUN);
`ifdef BCD_SUB_EN
    launchCarry = sub_i ? 1'b1 : cin_i;
`else
    launchCarry = cin_i;
`endif
  end

  // Next-state and datapath update. The visible result registers are only
  // written on the last digit, so they never expose a partial sum.
  always_comb begin
    state_d   = state_q;
    opA_d     = opA_q;
    opB_d     = opB_q;
    carry_d   = carry_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    invAcc_d  = invAcc_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    invalid_d = invalid_q;
`ifdef BCD_SUB_EN
    subMode_d = subMode_q;
`endif

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      RUN: begin
        opA_d    = opA_q >> 4;
        opB_d    = opB_q >> 4;
        carry_d  = digitCarry;
        acc_d    = accNext;
        invAcc_d = invAcc_q | digitInvalid;
        idx_d    = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          state_d   = DONE;
          sum_d     = accNext;
          cout_d    = digitCarry;
          invalid_d = invAcc_q | digitInvalid;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (launch) begin
      state_d  = RUN;
      opA_d    = a_i;
      opB_d    = b_i;
      carry_d  = launchCarry;
      idx_d    = '0;
      acc_d    = '0;
      invAcc_d = 1'b0;
`ifdef BCD_SUB_EN
      subMode_d = sub_i;
`endif
    end
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      opA_q     <= '0;
      opB_q     <= '0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      acc_q     <= '0;
      invAcc_q  <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      invalid_q <= 1'b0;
`ifdef BCD_SUB_EN
      subMode_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      opA_q     <= opA_d;
      opB_q     <= opB_d;
      carry_q   <= carry_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      invAcc_q  <= invAcc_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      invalid_q <= invalid_d;
`ifdef BCD_SUB_EN
      subMode_q <= subMode_d;
`endif
    end
  end

  assign busy_o    = (state_q == RUN);
  assign done_o    = (state_q == DONE);
  assign sum_o     = sum_q;
  assign cout_o    = cout_q;
  assign invalid_o = invalid_q;

endmodule

// File: tb/tb_bcd_adder_serial.sv
// ---------------------------------------------------------------------------
// tb_bcd_adder_serial
//
// Directed bench for bcd_adder_serial with DIGITS=4. Inputs are driven and
// outputs sampled on the falling clock edge, away from the active edge.
// Expected values are worked out by hand from the decimal digit rule.
// ---------------------------------------------------------------------------
module tb_bcd_adder_serial;

  logic        clk;
  logic        rst_n;
  logic        startIn;
  logic [15:0] aIn;
  logic [15:0] bIn;
  logic        cinIn;
  logic        subIn;
  logic        busyOut;
  logic        doneOut;
  logic [15:0] sumOut;
  logic        coutOut;
  logic        invalidOut;

  int passCount;
  int checkCount;
  int cycles;
  int extraDone;

  bcd_adder_serial #(.DIGITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (startIn),
    .a_i       (aIn),
    .b_i       (bIn),
    .cin_i     (cinIn),
`ifdef BCD_SUB_EN
    .sub_i     (subIn),
`endif
    .busy_o    (busyOut),
    .done_o    (doneOut),
    .sum_o     (sumOut),
    .cout_o    (coutOut),
    .invalid_o (invalidOut)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: the pass counter printed in the summary is stepped here.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Presents one request for a single clock; returns at the falling edge
  // right after the sampling edge, i.e. during the first busy cycle.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic cin, input logic sub);
    @(negedge clk);
    aIn     = a;
    bIn     = b;
    cinIn   = cin;
    subIn   = sub;
    startIn = 1'b1;
    @(negedge clk);
    startIn = 1'b0;
    aIn     = 16'h0F0F;
    bIn     = 16'hF0F0;
    cinIn   = ~cin;
    subIn   = ~sub;
  endtask

  // Advances falling edges until done is seen, bounded; cycles counts edges
  // since the sampling edge of the request.
  task automatic waitDone(input int startCount, output int count);
    count = startCount;
    while (doneOut !== 1'b1 && count < 20) begin
      @(negedge clk);
      count++;
    end
  endtask

  initial begin
    passCount  = 0;
    checkCount = 0;
    startIn    = 1'b0;
    aIn        = '0;
    bIn        = '0;
    cinIn      = 1'b0;
    subIn      = 1'b0;
    rst_n      = 1'b1;
    #2 rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", busyOut, 0);
    checkOutput("reset_done", doneOut, 0);
    checkOutput("reset_sum", sumOut, 0);
    checkOutput("reset_cout", coutOut, 0);
    checkOutput("reset_invalid", invalidOut, 0);
    rst_n = 1'b1;

    // Test 1: 1234 + 5678 = 6912, busy for four cycles, done after edge 5.
    applyStimulus(16'h1234, 16'h5678, 1'b0, 1'b0);
    checkOutput("t1_busy_c1", busyOut, 1);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      checkOutput("t1_busy_run", busyOut, 1);
      checkOutput("t1_done_early", doneOut, 0);
    end
    @(negedge clk);
    checkOutput("t1_done", doneOut, 1);
    checkOutput("t1_busy_done", busyOut, 0);
    checkOutput("t1_sum", sumOut, 32'h6912);
    checkOutput("t1_cout", coutOut, 0);
    checkOutput("t1_invalid", invalidOut, 0);
    @(negedge clk);
    checkOutput("t1_done_pulse", doneOut, 0);
    checkOutput("t1_sum_hold", sumOut, 32'h6912);

    // Test 2: 9999 + 0001 = 0000 carry 1, then back-to-back 9999+9999+1.
    applyStimulus(16'h9999, 16'h0001, 1'b0, 1'b0);
    waitDone(1, cycles);
    checkOutput("t2a_latency", cycles, 5);
    checkOutput("t2a_sum", sumOut, 32'h0000);
    checkOutput("t2a_cout", coutOut, 1);
    aIn     = 16'h9999;
    bIn     = 16'h9999;
    cinIn   = 1'b1;
    startIn = 1'b1;
    @(negedge clk);
    startIn = 1'b0;
    checkOutput("t2b_busy", busyOut, 1);
    waitDone(1, cycles);
    checkOutput("t2b_spacing", cycles, 5);
    checkOutput("t2b_sum", sumOut, 32'h9999);
    checkOutput("t2b_cout", coutOut, 1);

    // Test 3: an out-of-range digit flags invalid; next valid op clears it.
    applyStimulus(16'h00A3, 16'h0001, 1'b0, 1'b0);
    waitDone(1, cycles);
    checkOutput("t3a_latency", cycles, 5);
    checkOutput("t3a_invalid", invalidOut, 1);
    checkOutput("t3a_sum", sumOut, 32'h0104);
    checkOutput("t3a_cout", coutOut, 0);
    applyStimulus(16'h0001, 16'h0002, 1'b0, 1'b0);
    waitDone(1, cycles);
    checkOutput("t3b_invalid", invalidOut, 0);
    checkOutput("t3b_sum", sumOut, 32'h0003);

    // Test 4: a request during busy is ignored.
    applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0);
    aIn     = 16'h5555;
    bIn     = 16'h5555;
    startIn = 1'b1;
    @(negedge clk);
    startIn = 1'b0;
    waitDone(2, cycles);
    checkOutput("t4_latency", cycles, 5);
    checkOutput("t4_sum", sumOut, 32'h3333);
    extraDone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (doneOut === 1'b1) extraDone++;
    end
    checkOutput("t4_extra_done", extraDone, 0);
    checkOutput("t4_idle", busyOut, 0);

    // Test 5: reset mid-RUN clears outputs immediately, no done follows.
    applyStimulus(16'h4321, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_busy", busyOut, 0);
    checkOutput("t5_sum", sumOut, 0);
    checkOutput("t5_cout", coutOut, 0);
    checkOutput("t5_invalid", invalidOut, 0);
    @(negedge clk);
    checkOutput("t5_done", doneOut, 0);
    rst_n = 1'b1;
    extraDone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (doneOut === 1'b1) extraDone++;
    end
    checkOutput("t5_no_done", extraDone, 0);
    applyStimulus(16'h4321, 16'h1111, 1'b0, 1'b0);
    waitDone(1, cycles);
    checkOutput("t5_fresh_latency", cycles, 5);
    checkOutput("t5_fresh_sum", sumOut, 32'h5432);
    checkOutput("t5_fresh_cout", coutOut, 0);

`ifdef BCD_SUB_EN
    // Test 6: subtraction through nines complement.
    applyStimulus(16'h0500, 16'h0123, 1'b0, 1'b1);
    waitDone(1, cycles);
    checkOutput("t6a_sum", sumOut, 32'h0377);
    checkOutput("t6a_cout", coutOut, 1);
    applyStimulus(16'h0123, 16'h0500, 1'b0, 1'b1);
    waitDone(1, cycles);
    checkOutput("t6b_sum", sumOut, 32'h9623);
    checkOutput("t6b_cout", coutOut, 0);
    applyStimulus(16'h0002, 16'h0003, 1'b1, 1'b0);
    waitDone(1, cycles);
    checkOutput("t6c_add_sum", sumOut, 32'h0006);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
